// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch front end with one-outstanding memory handshake and one-entry fetch buffer
//   clk, rst              : clock, synchronous active-high reset
//   PCwrite, IFIDwrite    : hazard-unit stall controls (0 = hold PC issue / hold IF/ID)
//   branch_taken/_target  : ID-stage redirect
//   imem_req/addr/gnt     : fetch request handshake
//   imem_rvalid/rdata     : fetch response
//   IFID_instr/pc4/valid  : IF/ID pipeline register
//   stall_cycles          : saturating count of cycles with IFIDwrite=0
module fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   PCwrite,
    input  logic                   IFIDwrite,
    input  logic                   branch_taken,
    input  logic [31:0]            branch_target,
    output logic                   imem_req,
    output logic [31:0]            imem_addr,
    input  logic                   imem_gnt,
    input  logic                   imem_rvalid,
    input  logic [31:0]            imem_rdata,
    output logic [31:0]            IFID_instr,
    output logic [31:0]            IFID_pc4,
    output logic                   IFID_valid,
    output logic [STALL_CNT_W-1:0] stall_cycles
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_FULL} state_t;
    state_t                 r_state, w_state_nxt;
    logic                   r_squash, w_squash_nxt;
    logic [31:0]            r_pc, r_req_pc4, r_buf_instr, r_buf_pc4;
    logic [31:0]            r_ifid_instr, r_ifid_pc4;
    logic                   r_ifid_valid;
    logic [STALL_CNT_W-1:0] r_stall;
    logic                   w_br, w_grant, w_acc, w_full;
    // redirect only counts when IF/ID can take the bubble
    assign w_br     = branch_taken & IFIDwrite;
    assign w_full   = r_state == S_FULL;
    assign imem_req = !rst && r_state == S_REQ && PCwrite && !w_br;
    assign w_grant  = imem_req & imem_gnt;
    // a response coinciding with a redirect is dropped
    assign w_acc    = r_state == S_WAIT && imem_rvalid && !r_squash && !w_br;
    assign imem_addr    = r_pc;
    assign IFID_instr   = r_ifid_instr;
    assign IFID_pc4     = r_ifid_pc4;
    assign IFID_valid   = r_ifid_valid;
    assign stall_cycles = r_stall;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_REQ;
            r_squash <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_squash <= w_squash_nxt;
        end
    end
    always_comb begin
        w_state_nxt  = r_state;
        w_squash_nxt = r_squash;
        if (w_br) begin
            // an in-flight request with no response yet must be squashed when it lands
            w_squash_nxt = r_state == S_WAIT && !imem_rvalid;
            w_state_nxt  = w_squash_nxt ? S_WAIT : S_REQ;
        end else begin
            case (r_state)
                S_REQ:   w_state_nxt = w_grant ? S_WAIT : S_REQ;
                S_WAIT:  if (imem_rvalid) begin
                             w_squash_nxt = 1'b0;
                             w_state_nxt  = (r_squash || IFIDwrite) ? S_REQ : S_FULL;
                         end
                S_FULL:  w_state_nxt = IFIDwrite ? S_REQ : S_FULL;
                default: w_state_nxt = S_REQ;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_req_pc4    <= 32'h0;
            r_buf_instr  <= 32'h0;
            r_buf_pc4    <= 32'h0;
            r_ifid_instr <= 32'h0;
            r_ifid_pc4   <= 32'h0;
            r_ifid_valid <= 1'b0;
            r_stall      <= '0;
        end else begin
            if (w_br)
                r_pc <= branch_target;
            else if (w_grant) begin
                r_pc      <= r_pc + 32'd4;
                r_req_pc4 <= r_pc + 32'd4;
            end
            if (w_acc && !IFIDwrite) begin
                r_buf_instr <= imem_rdata;
                r_buf_pc4   <= r_req_pc4;
            end
            if (IFIDwrite) begin
                r_ifid_instr <= w_br ? 32'h0 : w_full ? r_buf_instr : w_acc ? imem_rdata : 32'h0;
                r_ifid_pc4   <= w_br ? 32'h0 : w_full ? r_buf_pc4   : w_acc ? r_req_pc4  : 32'h0;
                r_ifid_valid <= !w_br && (w_full || w_acc);
            end
            if (!IFIDwrite && !(&r_stall))
                r_stall <= r_stall + 1'b1;
        end
    end
endmodule
